ldr_host_sequencer: RTL and testbench
=====================================

// Module: ldr_host_sequencer
// PURPOSE
//  Avalon-MM master that drives the LDRavalonWrapper register map in hardware:
//  accepts an autocorrelation vector R0..R(ORDER) on a valid/ready stream, resets and
//  loads the LDR core, starts it, polls done, then reads A0..A(ORDER) back out on a
//  valid/ready stream. Sits between the autocorrelation stage and the LPC coefficient
//  consumer.
// PARAMETERS
//  DW        16    data width (writedata, readdata, stream words)
//  AW        16    Avalon address width
//  ORDER     10    LPC order; ORDER+1 words in and out
//  REG_CTRL  0     reset register (write 1 then 0)
//  REG_START 1     start register (write 1 then 0)
//  REG_DONE  2     done register; bit0 = done
//  R_BASE    3     address of R0; Rk at R_BASE+k
//  A_BASE    14    address of A0; Ak at A_BASE+k
//  POLL_MAX  4096  done polls before timeout (>=1)
// PORTS
//  clk        in   1     clock
//  rst        in   1     asynchronous reset, active low
//  address    out  AW    Avalon address
//  read       out  1     Avalon read strobe, one cycle per access
//  write      out  1     Avalon write strobe, one cycle per access
//  writedata  out  DW    Avalon write data
//  readdata   in   DW    Avalon read data, valid exactly 1 cycle after read
//  r_valid    in   1     R word valid
//  r_ready    out  1     R word accepted when r_valid & r_ready
//  r_data     in   DW    signed R word, R0 first
//  a_valid    out  1     A word valid, held until a_ready
//  a_ready    in   1     consumer ready
//  a_data     out  DW    signed A word, A0 first
//  a_last     out  1     high with A(ORDER)
//  busy       out  1     high from job start until last A accepted / timeout
//  error      out  1     sticky poll timeout; cleared at next job start
// BEHAVIOUR
//  - All outputs registered; on rst low all outputs 0, state IDLE, counters 0.
//  - Slave has no waitrequest; read latency fixed at 1; one access per cycle max.
//  - States: IDLE -> RST1 -> RST0 -> LOADR -> STA1 -> STA0 -> POLL -> PWAIT
//    -> RDA -> AWAIT -> AOUT -> (RDA | IDLE); PWAIT -> IDLE on timeout.
//  - IDLE: r_ready=0. When r_valid=1: busy<=1, error<=0, go RST1. r_data not consumed.
//  - RST1/RST0: write REG_CTRL=1, then REG_CTRL=0, one cycle each.
//  - LOADR: r_ready=1. Each handshake issues write R_BASE+k, r_data, on the next cycle;
//    k increments per handshake; after k=ORDER accepted, r_ready<=0, go STA1. Gaps in
//    r_valid allowed (write=0 on those cycles).
//  - STA1/STA0: write REG_START=1, then 0.
//  - POLL: read REG_DONE for one cycle; PWAIT samples readdata. bit0=1 -> RDA, k=0.
//    Else poll count +1; count==POLL_MAX -> error<=1, busy<=0, IDLE, no A output.
//    Otherwise back to POLL (one poll every 2 cycles).
//  - RDA: read A_BASE+k; AWAIT: a_data<=readdata, a_valid<=1, a_last<=(k==ORDER).
//  - AOUT: hold a_data/a_valid/a_last stable until a_ready; on handshake a_valid<=0;
//    if k==ORDER busy<=0 -> IDLE, else k+1 -> RDA. No read issued while a_valid=1.
//  - a_ready high before a_valid is harmless; no handshake without a_valid.
//  - read and write never both high; address/writedata hold last value when idle.
//  - r_valid outside LOADR ignored (r_ready=0); a_ready outside AOUT ignored.
//  - Reset mid-job: immediate return to IDLE, partial stream dropped; next job always
//    re-resets the LDR core first, so no slave recovery needed.
//  - Words pass through unmodified (no sign/width change); counters sized for ORDER,
//    POLL_MAX.
// TESTING
//  - Reset: hold rst low 3 cycles -> all outputs 0, r_ready=0, busy=0.
//  - Load: R = 32767,25742,16169,9836,4569,-2674,-11249,-17338,-14853,-6828,-3174
//    -> write sequence (0,1),(0,0),(3..13,R),(1,1),(1,0), each write 1 cycle.
//  - Done after 5 polls, model returns A=4096,-k... -> exactly 6 reads of addr 2,
//    then 11 reads addr 14..24, a_data matches, a_last only on 11th word.
//  - Backpressure: a_ready low 7 cycles on word 3 -> a_data stable, no read issued.
//  - Timeout: POLL_MAX=8, done never set -> 8 polls, error=1, busy=0, no a_valid;
//    next job clears error.
//  - Reset asserted during LOADR after 4 words -> IDLE; new job restarts with RST1.

Source files
------------

// File: rtl/ldr_host_sequencer_if.sv
// Avalon-MM master bus plus R-in / A-out streams and status of the LDR host sequencer.
// The sequencer drives through 'master'; the register slave and the stream peers connect through 'slave'.
interface ldr_host_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic [AW-1:0] address;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;

    logic          r_valid;
    logic          r_ready;
    logic [DW-1:0] r_data;

    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] a_data;
    logic          a_last;

    logic          busy;
    logic          error;

    modport master (
        output address, read, write, writedata, r_ready,
               a_valid, a_data, a_last, busy, error,
        input  readdata, r_valid, r_data, a_ready
    );

    modport slave (
        input  address, read, write, writedata, r_ready,
               a_valid, a_data, a_last, busy, error,
        output readdata, r_valid, r_data, a_ready
    );
endinterface

// File: rtl/ldr_host_sequencer.sv
// Avalon-MM master that resets/loads/starts the LDR core, polls done, and streams A0..A(ORDER) out.
// Latency: 4 cycles after the last R word to the first done poll; each A word is valid 2 cycles after its read is issued.
// Backpressure: r_ready is asserted only while loading; a_valid/a_data/a_last hold until a_ready, and no read is issued meanwhile.
module ldr_host_sequencer #(
    parameter int DW        = 16,
    parameter int AW        = 16,
    parameter int ORDER     = 10,
    parameter int REG_CTRL  = 0,
    parameter int REG_START = 1,
    parameter int REG_DONE  = 2,
    parameter int R_BASE    = 3,
    parameter int A_BASE    = 14,
    parameter int POLL_MAX  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    ldr_host_sequencer_if.master bus
);

    localparam int KW = $clog2(ORDER + 2);
    localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(ORDER);
    localparam logic [KW-1:0] K_LOADED = KW'(ORDER + 1);
    localparam logic [PW-1:0] P_LAST   = PW'(POLL_MAX - 1);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] RST1  = 4'd1;
    localparam logic [3:0] RST0  = 4'd2;
    localparam logic [3:0] LOADR = 4'd3;
    localparam logic [3:0] STA1  = 4'd4;
    localparam logic [3:0] STA0  = 4'd5;
    localparam logic [3:0] POLL  = 4'd6;
    localparam logic [3:0] PWAIT = 4'd7;
    localparam logic [3:0] RDA   = 4'd8;
    localparam logic [3:0] AWAIT = 4'd9;
    localparam logic [3:0] AOUT  = 4'd10;

    logic [3:0]    state;
    logic [KW-1:0] k;
    logic [PW-1:0] pcnt;
    logic          hs_r;
    logic          hs_a;

    assign hs_r = bus.r_valid & bus.r_ready;
    assign hs_a = bus.a_valid & bus.a_ready;

    // Bus outputs are registered: each transition sets up the access seen during the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            k             <= '0;
            pcnt          <= '0;
            bus.address   <= '0;
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            bus.writedata <= '0;
            bus.r_ready   <= 1'b0;
            bus.a_valid   <= 1'b0;
            bus.a_data    <= '0;
            bus.a_last    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.r_valid) begin
                        bus.busy      <= 1'b1;
                        bus.error     <= 1'b0;
                        bus.write     <= 1'b1;
                        bus.address   <= AW'(REG_CTRL);
                        bus.writedata <= DW'(1);
                        state         <= RST1;
                    end
                end
                RST1: begin
                    bus.write     <= 1'b1;
                    bus.address   <= AW'(REG_CTRL);
                    bus.writedata <= '0;
                    state         <= RST0;
                end
                RST0: begin
                    bus.write   <= 1'b0;
                    bus.r_ready <= 1'b1;
                    k           <= '0;
                    state       <= LOADR;
                end
                LOADR: begin
                    // k parks at ORDER+1 for the cycle that carries the last R write.
                    if (k == K_LOADED) begin
                        bus.write     <= 1'b1;
                        bus.address   <= AW'(REG_START);
                        bus.writedata <= DW'(1);
                        state         <= STA1;
                    end else if (hs_r) begin
                        bus.write     <= 1'b1;
                        bus.address   <= AW'(R_BASE) + AW'(k);
                        bus.writedata <= bus.r_data;
                        k             <= k + 1'b1;
                        if (k == K_LAST) begin
                            bus.r_ready <= 1'b0;
                        end
                    end else begin
                        bus.write <= 1'b0;
                    end
                end
                STA1: begin
                    bus.write     <= 1'b1;
                    bus.address   <= AW'(REG_START);
                    bus.writedata <= '0;
                    state         <= STA0;
                end
                STA0: begin
                    bus.write   <= 1'b0;
                    bus.read    <= 1'b1;
                    bus.address <= AW'(REG_DONE);
                    pcnt        <= '0;
                    state       <= POLL;
                end
                POLL: begin
                    bus.read <= 1'b0;
                    state    <= PWAIT;
                end
                PWAIT: begin
                    if (bus.readdata[0]) begin
                        bus.read    <= 1'b1;
                        bus.address <= AW'(A_BASE);
                        k           <= '0;
                        state       <= RDA;
                    end else if (pcnt == P_LAST) begin
                        bus.error <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        pcnt     <= pcnt + 1'b1;
                        bus.read <= 1'b1;
                        state    <= POLL;
                    end
                end
                RDA: begin
                    bus.read <= 1'b0;
                    state    <= AWAIT;
                end
                AWAIT: begin
                    bus.a_data  <= bus.readdata;
                    bus.a_valid <= 1'b1;
                    bus.a_last  <= (k == K_LAST);
                    state       <= AOUT;
                end
                AOUT: begin
                    if (hs_a) begin
                        bus.a_valid <= 1'b0;
                        bus.a_last  <= 1'b0;
                        if (k == K_LAST) begin
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            k           <= k + 1'b1;
                            bus.read    <= 1'b1;
                            bus.address <= AW'(A_BASE) + AW'(k) + AW'(1);
                            state       <= RDA;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldr_host_sequencer.sv
// Directed-plus-random bench for ldr_host_sequencer: behavioural register slave, bus monitor,
// and expected write/read/A sequences rebuilt from the register-map rules for every job.
module tb_ldr_host_sequencer;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int ORDER = 10;
    localparam int NW    = ORDER + 1;
    localparam int PM    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ldr_host_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    ldr_host_sequencer #(
        .DW(DW), .AW(AW), .ORDER(ORDER), .REG_CTRL(0), .REG_START(1), .REG_DONE(2),
        .R_BASE(3), .A_BASE(14), .POLL_MAX(PM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    int            rdir [NW] = '{32767, 25742, 16169, 9836, 4569, -2674, -11249, -17338, -14853, -6828, -3174};
    logic [DW-1:0] rvec [NW];
    logic [DW-1:0] avec [NW];
    int            done_after = 0;
    int            polls = 0;

    logic [AW-1:0] wr_a[$];
    logic [DW-1:0] wr_d[$];
    int            wr_c[$];
    logic [AW-1:0] rd_a[$];
    int            rd_c[$];
    int cyc = 0, both_hi = 0, rd_av = 0, unstable = 0, av_cnt = 0, a_hs = 0;
    logic          pav = 1'b0, par = 1'b0, pal = 1'b0;
    logic [DW-1:0] pad = '0;

    // Register slave: done after done_after polls, A registers from avec, garbage when not read.
    always @(posedge clk) begin
        if (bus.write && bus.address == AW'(0) && bus.writedata == DW'(1)) polls = 0;
        if (bus.read) begin
            if (bus.address == AW'(2)) begin
                bus.readdata <= (polls >= done_after) ? DW'(1) : DW'(0);
                polls++;
            end else if (bus.address >= AW'(14) && bus.address <= AW'(24)) begin
                bus.readdata <= avec[int'(bus.address) - 14];
            end else begin
                bus.readdata <= DW'(16'hdead);
            end
        end else begin
            bus.readdata <= DW'($urandom);
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            pav = 1'b0;
            par = 1'b0;
        end else begin
            if (bus.write) begin wr_a.push_back(bus.address); wr_d.push_back(bus.writedata); wr_c.push_back(cyc); end
            if (bus.read) begin rd_a.push_back(bus.address); rd_c.push_back(cyc); end
            if (bus.read && bus.write) both_hi++;
            if (bus.read && bus.a_valid) rd_av++;
            if (pav && !par && (!bus.a_valid || bus.a_data !== pad || bus.a_last !== pal)) unstable++;
            if (bus.a_valid) av_cnt++;
            if (bus.a_valid && bus.a_ready) a_hs++;
            pav = bus.a_valid; par = bus.a_ready; pad = bus.a_data; pal = bus.a_last;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_a.delete(); wr_d.delete(); wr_c.delete(); rd_a.delete(); rd_c.delete();
        both_hi = 0; rd_av = 0; unstable = 0; av_cnt = 0; a_hs = 0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input int gap);
        int n;
        n = 0;
        bus.r_valid = 1'b1;
        bus.r_data  = d;
        while (!bus.r_ready && n < 100) begin tick(); n++; end
        chk("r_ready_wait", 32'(bus.r_ready), 32'd1);
        tick();
        bus.r_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_job(input int dafter, input bit exp_to);
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        logic [AW-1:0] er[$];
        int npoll, n, hold;
        clear_mon();
        done_after = dafter;
        for (int i = 0; i < NW; i++) begin
            send_word(rvec[i], $urandom_range(0, 2));
            if (i == 0) begin
                chk("busy_at_load", 32'(bus.busy), 32'd1);
                chk("error_cleared", 32'(bus.error), 32'd0);
            end
        end
        if (!exp_to) begin
            for (int w = 0; w < NW; w++) begin
                n = 0;
                while (!bus.a_valid && n < 100) begin tick(); n++; end
                chk("a_valid_wait", 32'(bus.a_valid), 32'd1);
                hold = (w == 3) ? 7 : $urandom_range(0, 2);
                if (hold > 0) begin bus.a_ready = 1'b0; repeat (hold) tick(); end
                chk($sformatf("a_data%0d", w), 32'(bus.a_data), 32'(avec[w]));
                chk($sformatf("a_last%0d", w), 32'(bus.a_last), (w == ORDER) ? 32'd1 : 32'd0);
                bus.a_ready = 1'b1;
                tick();
                bus.a_ready = 1'($urandom_range(0, 1));
            end
            tick();
            chk("busy_end", 32'(bus.busy), 32'd0);
            chk("a_valid_end", 32'(bus.a_valid), 32'd0);
            chk("a_hs_count", 32'(a_hs), 32'(NW));
            npoll = dafter + 1;
        end else begin
            n = 0;
            while (bus.busy && n < 200) begin tick(); n++; end
            tick();
            chk("busy_timeout", 32'(bus.busy), 32'd0);
            chk("error_timeout", 32'(bus.error), 32'd1);
            chk("no_a_valid", 32'(av_cnt), 32'd0);
            npoll = PM;
        end
        bus.a_ready = 1'b0;
        ea = '{AW'(0), AW'(0)}; ed = '{DW'(1), DW'(0)};
        for (int i = 0; i < NW; i++) begin ea.push_back(AW'(3 + i)); ed.push_back(rvec[i]); end
        ea.push_back(AW'(1)); ed.push_back(DW'(1));
        ea.push_back(AW'(1)); ed.push_back(DW'(0));
        chk("wr_count", 32'(wr_a.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
            chk($sformatf("wr%0d_addr", i), 32'(wr_a[i]), 32'(ea[i]));
            chk($sformatf("wr%0d_data", i), 32'(wr_d[i]), 32'(ed[i]));
        end
        if (wr_c.size() == ea.size()) begin
            chk("ctrl_pair_gap", 32'(wr_c[1] - wr_c[0]), 32'd1);
            chk("start_pair_gap", 32'(wr_c[NW + 3] - wr_c[NW + 2]), 32'd1);
        end
        for (int i = 0; i < npoll; i++) er.push_back(AW'(2));
        if (!exp_to) for (int i = 0; i < NW; i++) er.push_back(AW'(14 + i));
        chk("rd_count", 32'(rd_a.size()), 32'(er.size()));
        for (int i = 0; i < er.size() && i < rd_a.size(); i++)
            chk($sformatf("rd%0d_addr", i), 32'(rd_a[i]), 32'(er[i]));
        for (int i = 1; i < npoll && i < rd_c.size(); i++)
            chk($sformatf("poll%0d_spacing", i), 32'(rd_c[i] - rd_c[i - 1]), 32'd2);
        chk("rd_wr_overlap", 32'(both_hi), 32'd0);
        chk("rd_while_a_valid", 32'(rd_av), 32'd0);
        chk("a_stable", 32'(unstable), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.r_valid = 1'b0;
        bus.r_data  = '0;
        bus.a_ready = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_address", 32'(bus.address), 32'd0);
        chk("rst_read", 32'(bus.read), 32'd0);
        chk("rst_write", 32'(bus.write), 32'd0);
        chk("rst_writedata", 32'(bus.writedata), 32'd0);
        chk("rst_r_ready", 32'(bus.r_ready), 32'd0);
        chk("rst_a_valid", 32'(bus.a_valid), 32'd0);
        chk("rst_a_data", 32'(bus.a_data), 32'd0);
        chk("rst_a_last", 32'(bus.a_last), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        rst = 1'b1;
        tick();

        // Directed R vector, A = 4096, -1, -2, ...; done on the sixth poll.
        for (int i = 0; i < NW; i++) begin
            rvec[i] = DW'(rdir[i]);
            avec[i] = (i == 0) ? DW'(4096) : DW'(-i);
        end
        do_job(5, 1'b0);

        // Done never set: times out after PM polls.
        for (int i = 0; i < NW; i++) rvec[i] = DW'($urandom);
        do_job(1000, 1'b1);

        // Random job right after a timeout; error must clear at job start.
        for (int i = 0; i < NW; i++) begin rvec[i] = DW'($urandom); avec[i] = DW'($urandom); end
        do_job($urandom_range(0, 5), 1'b0);

        // Reset in the middle of loading R.
        clear_mon();
        for (int i = 0; i < 4; i++) send_word(DW'($urandom), 0);
        rst = 1'b0;
        tick();
        tick();
        chk("midrst_r_ready", 32'(bus.r_ready), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_write", 32'(bus.write), 32'd0);
        chk("midrst_address", 32'(bus.address), 32'd0);
        chk("midrst_writedata", 32'(bus.writedata), 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < NW; i++) begin rvec[i] = DW'($urandom); avec[i] = DW'($urandom); end
        do_job(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
